// File: rtl/pc_unit.sv
// Program counter with priority next-PC selection and an optional return-address stack.
// Define PC_UNIT_RAS_EN to build the return-address stack in; otherwise ret behaves as a plain jump.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        stall_i,
    input  logic                        redirect_valid_i,
    input  logic [WIDTH-1:0]            redirect_target_i,
    input  logic [1:0]                  pc_src_i,
    input  logic [WIDTH-1:0]            imm_ext_i,
    input  logic [WIDTH-1:0]            jump_target_i,
    input  logic                        call_i,
    input  logic                        ret_i,
    output logic [WIDTH-1:0]            pc_o,
    output logic [WIDTH-1:0]            pc_plus4_o,
    output logic [$clog2(RAS_DEPTH):0]  ras_count_o,
    output logic                        misaligned_o,
    output logic                        ras_underflow_o
);

    localparam int unsigned      CW   = $clog2(RAS_DEPTH) + 1;
    localparam int unsigned      PW   = $clog2(RAS_DEPTH);
    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);
`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pcPlus4_q, pcPlus4_d;
    logic             misaligned_q, misaligned_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] rawTarget;
    logic             loadEn;
    logic             retHit;
    logic [WIDTH-1:0] topEntry;

`ifdef PC_UNIT_RAS_EN
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    topPtr;
    logic [PW-1:0]    pushPtr;
    logic             pushEn;
    logic [CW-1:0]    count_q, count_d;

    assign topPtr   = wrPtr_q - PW'(1);
    assign topEntry = ras_q[topPtr];
    assign retHit   = ret_i && (count_q != '0);

    // A simultaneous call+ret reuses the popped slot, so pointer and count stay put.
    always_comb begin
        count_d = count_q;
        wrPtr_d = wrPtr_q;
        pushEn  = 1'b0;
        pushPtr = wrPtr_q;
        if (redirect_valid_i) begin
            count_d = '0;
        end else if (!stall_i) begin
            if (call_i && retHit) begin
                pushEn  = 1'b1;
                pushPtr = topPtr;
            end else if (call_i) begin
                pushEn  = 1'b1;
                wrPtr_d = wrPtr_q + PW'(1);
                if (count_q != CW'(RAS_DEPTH)) begin
                    count_d = count_q + CW'(1);
                end
            end else if (retHit) begin
                wrPtr_d = topPtr;
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            wrPtr_q <= '0;
        end else begin
            count_q <= count_d;
            wrPtr_q <= wrPtr_d;
        end
    end

    // Entries carry no reset; only the ras_count newest slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (pushEn) begin
            ras_q[pushPtr] <= pcPlus4_q;
        end
    end

    assign ras_count_o = count_q;
`else
    logic unusedCall;

    assign unusedCall  = call_i;
    assign retHit      = 1'b0;
    assign topEntry    = '0;
    assign ras_count_o = '0;
`endif

    always_comb begin
        rawTarget    = pc_q;
        loadEn       = 1'b1;
        underflow_d  = 1'b0;
        misaligned_d = 1'b0;
        pc_d         = pc_q;
        pcPlus4_d    = pcPlus4_q;
        if (redirect_valid_i) begin
            rawTarget = redirect_target_i;
        end else if (stall_i) begin
            loadEn = 1'b0;
        end else if (ret_i) begin
            if (retHit) begin
                rawTarget = topEntry;
            end else begin
                rawTarget   = jump_target_i;
                underflow_d = RAS_EN;
            end
        end else begin
            unique case (pc_src_i)
                2'b01:   rawTarget = pc_q + imm_ext_i;
                2'b10:   rawTarget = jump_target_i;
                default: rawTarget = pcPlus4_q;
            endcase
        end
        if (loadEn) begin
            misaligned_d = |rawTarget[1:0];
            pc_d         = {rawTarget[WIDTH-1:2], 2'b00};
            pcPlus4_d    = pc_d + FOUR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q         <= RESET_VECTOR;
            pcPlus4_q    <= RESET_VECTOR + FOUR;
            misaligned_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pcPlus4_q    <= pcPlus4_d;
            misaligned_q <= misaligned_d;
            underflow_q  <= underflow_d;
        end
    end

    assign pc_o            = pc_q;
    assign pc_plus4_o      = pcPlus4_q;
    assign misaligned_o    = misaligned_q;
    assign ras_underflow_o = underflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; covers both the plain build and the PC_UNIT_RAS_EN build.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        stall = 1'b0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectTarget = '0;
    logic [1:0]  pcSrc = 2'b00;
    logic [31:0] immExt = '0;
    logic [31:0] jumpTarget = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [2:0]  rasCount;
    logic        misaligned;
    logic        rasUnderflow;

    int checks = 0;
    int failures = 0;

    pc_unit #(
        .WIDTH(32),
        .RESET_VECTOR(32'h0000_0800),
        .RAS_DEPTH(4)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .stall_i(stall),
        .redirect_valid_i(redirectValid),
        .redirect_target_i(redirectTarget),
        .pc_src_i(pcSrc),
        .imm_ext_i(immExt),
        .jump_target_i(jumpTarget),
        .call_i(call),
        .ret_i(ret),
        .pc_o(pc),
        .pc_plus4_o(pcPlus4),
        .ras_count_o(rasCount),
        .misaligned_o(misaligned),
        .ras_underflow_o(rasUnderflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkPc(input string tag, input logic [31:0] expPc, input logic expMis);
        checkOutput({tag, ".pc"}, pc, expPc);
        checkOutput({tag, ".pc_plus4"}, pcPlus4, expPc + 32'd4);
        checkOutput({tag, ".misaligned"}, 32'(misaligned), 32'(expMis));
    endtask

    task automatic checkRas(input string tag, input logic [2:0] expCount, input logic expUnder);
        checkOutput({tag, ".ras_count"}, 32'(rasCount), 32'(expCount));
        checkOutput({tag, ".ras_underflow"}, 32'(rasUnderflow), 32'(expUnder));
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rt, input logic st,
                                 input logic [1:0] src, input logic [31:0] imm,
                                 input logic [31:0] jt, input logic c, input logic r);
        redirectValid  = rv;
        redirectTarget = rt;
        stall          = st;
        pcSrc          = src;
        immExt         = imm;
        jumpTarget     = jt;
        call           = c;
        ret            = r;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        #2;
        checkPc("reset", 32'h800, 1'b0);
        checkRas("reset", 3'd0, 1'b0);
        #9 rst_ni = 1'b1;
        cyc();
        checkPc("first_seq", 32'h804, 1'b0);

        applyStimulus(1'b1, 32'h100, 1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc();
        checkPc("redir_100", 32'h100, 1'b0);
        checkRas("redir_100", 3'd0, 1'b0);

        applyStimulus(1'b0, 32'h0, 1'b1, 2'b01, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0);
        cyc();
        checkPc("stall_hold", 32'h100, 1'b0);
        stall = 1'b0;
        cyc();
        checkPc("branch_back", 32'hF8, 1'b0);

        applyStimulus(1'b0, 32'h0, 1'b0, 2'b10, 32'h0, 32'h1003, 1'b0, 1'b0);
        cyc();
        checkPc("jump_misaligned", 32'h1000, 1'b1);
        pcSrc = 2'b00;
        cyc();
        checkPc("seq_00", 32'h1004, 1'b0);
        pcSrc = 2'b11;
        cyc();
        checkPc("seq_11", 32'h1008, 1'b0);

        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        checkPc("redir_top", 32'hFFFF_FFFC, 1'b0);
        redirectValid = 1'b0;
        cyc();
        checkPc("wrap_zero", 32'h0, 1'b0);

        applyStimulus(1'b0, 32'h0, 1'b0, 2'b01, 32'h22, 32'h0, 1'b0, 1'b0);
        cyc();
        checkPc("branch_misaligned", 32'h20, 1'b1);

        applyStimulus(1'b1, 32'h201, 1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
        cyc();
        checkPc("redir_misaligned", 32'h200, 1'b1);
        checkRas("redir_misaligned", 3'd0, 1'b0);

`ifdef PC_UNIT_RAS_EN
        applyStimulus(1'b1, 32'h10, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 2'b10, 32'h0, 32'(32'h20 + 32'h10 * i), 1'b1, 1'b0);
            cyc();
            checkPc("call_jump", 32'(32'h20 + 32'h10 * i), 1'b0);
            checkRas("call_count", (i < 4) ? 3'(i + 1) : 3'd4, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b01, 32'h400, 32'h900, 1'b0, 1'b1);
        cyc();
        checkPc("ret_1", 32'h54, 1'b0);
        checkRas("ret_1", 3'd3, 1'b0);
        cyc();
        checkPc("ret_2", 32'h44, 1'b0);
        cyc();
        checkPc("ret_3", 32'h34, 1'b0);
        cyc();
        checkPc("ret_4", 32'h24, 1'b0);
        checkRas("ret_4", 3'd0, 1'b0);
        cyc();
        checkPc("ret_underflow", 32'h900, 1'b0);
        checkRas("ret_underflow", 3'd0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        checkPc("after_underflow", 32'h904, 1'b0);
        checkRas("after_underflow", 3'd0, 1'b0);

        applyStimulus(1'b0, 32'h0, 1'b0, 2'b10, 32'h0, 32'hA00, 1'b1, 1'b0);
        cyc();
        checkRas("call_one", 3'd1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 2'b10, 32'h0, 32'hB00, 1'b1, 1'b0);
        cyc();
        checkPc("stall_call", 32'hA00, 1'b0);
        checkRas("stall_call", 3'd1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b10, 32'h0, 32'hB00, 1'b1, 1'b1);
        cyc();
        checkPc("call_ret", 32'h908, 1'b0);
        checkRas("call_ret", 3'd1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'hB00, 1'b1, 1'b0);
        cyc();
        checkRas("call_two", 3'd2, 1'b0);
        applyStimulus(1'b1, 32'h200, 1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc();
        checkPc("redir_clear", 32'h200, 1'b0);
        checkRas("redir_clear", 3'd0, 1'b0);
`else
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc();
        checkPc("call_ignored", 32'h204, 1'b0);
        checkRas("call_ignored", 3'd0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b01, 32'h40, 32'h80, 1'b0, 1'b1);
        cyc();
        checkPc("ret_as_jump", 32'h80, 1'b0);
        checkRas("ret_as_jump", 3'd0, 1'b0);
`endif

        applyStimulus(1'b1, 32'h40, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        checkPc("pre_reset", 32'h40, 1'b0);
        redirectValid = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        checkPc("async_reset", 32'h800, 1'b0);
        checkRas("async_reset", 3'd0, 1'b0);
        cyc();
        checkPc("reset_held", 32'h800, 1'b0);
        rst_ni = 1'b1;
        cyc();
        checkPc("reset_release", 32'h804, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC and address width in bits, minimum 8.
REQ-002 Parameter RESET_VECTOR, default 0: PC value loaded on reset, WIDTH bits, low two bits zero.
REQ-003 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, 2..16.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 stall  in  1  hold PC and stack this cycle.
REQ-007 redirect_valid  in  1  flush/exception redirect; highest priority.
REQ-008 redirect_target  in  WIDTH  redirect address.
REQ-009 pc_src  in  2  00 sequential, 01 branch (pc+imm_ext), 10 jump to jump_target, 11 sequential.
REQ-010 imm_ext  in  WIDTH  sign-extended branch offset.
REQ-011 jump_target  in  WIDTH  computed jump/JALR target.
REQ-012 call  in  1  current instruction is a call; push return address.
REQ-013 ret  in  1  current instruction is a return; pop stack for target.
REQ-014 pc  out  WIDTH  current PC, registered.
REQ-015 pc_plus4  out  WIDTH  pc+4, registered alongside pc.
REQ-016 ras_count  out  clog2(RAS_DEPTH)+1  valid stack entries.
REQ-017 misaligned  out  1  registered one-cycle pulse: last loaded target had nonzero bits [1:0].
REQ-018 ras_underflow  out  1  registered one-cycle pulse: ret taken with empty stack.

Function
REQ-019 Priority per cycle SHALL be: redirect_valid > stall > pc_src/ret.
REQ-020 redirect_valid SHALL load redirect_target, clear the stack (ras_count=0), and ignore stall, call and ret.
REQ-021 stall without redirect SHALL hold pc, pc_plus4, stack and ras_count; misaligned and ras_underflow SHALL be 0.
REQ-022 Otherwise next PC SHALL be: ret with ras_count>0 -> top of stack; ret with ras_count=0 -> jump_target plus ras_underflow=1; else pc_src 00/11 -> pc+4, 01 -> pc+imm_ext, 10 -> jump_target.
REQ-023 ret SHALL take precedence over pc_src.
REQ-024 All additions SHALL be modulo 2^WIDTH; wrap from all-ones region to 0 is not an error.
REQ-025 Any loaded target with bits [1:0] nonzero SHALL be loaded with bits [1:0] forced to 00, and misaligned SHALL pulse in the same cycle the PC updates.
REQ-026 pc_plus4 SHALL always equal the newly loaded pc+4 (mod 2^WIDTH), with no additional cycle of latency.
REQ-027 call (unstalled, no redirect) SHALL push current pc+4; ras_count increments, saturating at RAS_DEPTH.
REQ-028 Push when full SHALL overwrite the oldest entry as a circular buffer; the newest RAS_DEPTH entries remain.
REQ-029 ret with ras_count>0 SHALL pop the top entry; ras_count decrements.
REQ-030 call and ret together SHALL pop the top as target, then push pc+4 in its place; ras_count is unchanged; underflow rules of REQ-022 still apply.
REQ-031 The next-PC path SHALL be combinational from inputs to the PC register; a new target appears on pc one edge after it is presented.

Reset
REQ-032 Asserting rst SHALL immediately force pc=RESET_VECTOR, pc_plus4=RESET_VECTOR+4, ras_count=0, misaligned=0 and ras_underflow=0, regardless of clk.
REQ-033 Stack entry contents need not be reset; entries are valid only when counted by ras_count.
REQ-034 After rst deasserts, the first rising edge SHALL perform a normal update.

Configuration
REQ-035 Macro PC_UNIT_RAS_EN SHALL compile the return-address stack in.
REQ-036 Without PC_UNIT_RAS_EN: call is ignored; ret is treated as pc_src=10 (jump_target); ras_count and ras_underflow are tied to 0; stack storage is not instantiated.

Verification
REQ-037 rst low mid-run with pc=0x40 -> pc=RESET_VECTOR, pc_plus4=RESET_VECTOR+4 before the next edge; ras_count=0.
REQ-038 pc=0x100, pc_src=01, imm_ext=0xFFFFFFF8 -> pc=0xF8; same cycle with stall=1 -> pc stays 0x100.
REQ-039 RAS_DEPTH=4, five calls at pc=0x10,0x20,0x30,0x40,0x50, then five rets -> targets 0x54,0x44,0x34,0x24, then jump_target with ras_underflow=1.
REQ-040 redirect_valid=1 with stall=1, call=1, redirect_target=0x200 -> pc=0x200, ras_count=0.
REQ-041 pc_src=10, jump_target=0x1003 -> pc=0x1000, misaligned pulses for one cycle.
REQ-042 Build without PC_UNIT_RAS_EN: call then ret with jump_target=0x80 -> pc=0x80, ras_count=0, ras_underflow=0.
